// File: rtl/mem_wb_sram_stage.sv
// MEM/WB pipeline stage: multi-cycle SRAM loads/stores, upstream stall, writeback register.
// Optional write posting (stores do not stall) is enabled by defining SRAM_WRITE_POSTING_EN.
module mem_wb_sram_stage #(
    parameter int unsigned WAIT_CYCLES = 5,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned SRAM_AW     = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               WB_ENin,
    input  logic [1:0]         MEM_Signal,
    input  logic [31:0]        ALU_Res,
    input  logic [31:0]        ST_Val,
    input  logic [4:0]         destIn,
    output logic               pause,
    output logic               WB_ENout,
    output logic [4:0]         WB_Dest,
    output logic [31:0]        WB_Data,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic [31:0]        SRAM_WDATA,
    input  logic [31:0]        SRAM_RDATA,
    output logic               SRAM_CE_N,
    output logic               SRAM_WE_N
);

`ifdef SRAM_WRITE_POSTING_EN
    localparam bit Posting = 1'b1;
`else
    localparam bit Posting = 1'b0;
`endif

    localparam int unsigned CW = $clog2(WAIT_CYCLES + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic               is_store_q;
    logic [31:0]        rd_q;
    logic               is_load, is_store, mem_req, last;
    logic [SRAM_AW-1:0] word_addr;

    assign is_load   = (MEM_Signal == 2'b10);
    assign is_store  = (MEM_Signal == 2'b01);
    assign mem_req   = is_load | is_store;
    assign last      = (cnt_q == CW'(WAIT_CYCLES - 1));
    assign word_addr = SRAM_AW'((ALU_Res - 32'(BASE_ADDR)) >> 2);

    assign SRAM_CE_N = !(state_q == ACCESS);
    assign SRAM_WE_N = !((state_q == ACCESS) && is_store_q);

    always_comb begin
        pause   = 1'b0;
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    pause   = Posting ? is_load : 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // A posted store only stalls a following memory op.
                pause = (Posting && is_store_q) ? mem_req : 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                // A memory op waiting behind a posted store must not advance here.
                pause   = Posting && is_store_q && mem_req;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_store_q <= 1'b0;
            rd_q       <= '0;
            SRAM_ADDR  <= '0;
            SRAM_WDATA <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && mem_req) begin
                SRAM_ADDR  <= word_addr;
                SRAM_WDATA <= ST_Val;
                is_store_q <= is_store;
                cnt_q      <= '0;
            end else if (state_q == ACCESS) begin
                cnt_q <= cnt_q + CW'(1);
                if (last && !is_store_q) rd_q <= SRAM_RDATA;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WB_ENout <= 1'b0;
            WB_Dest  <= '0;
            WB_Data  <= '0;
        end else if (!pause) begin
            WB_ENout <= WB_ENin;
            WB_Dest  <= destIn;
            WB_Data  <= (state_q == DONE && !is_store_q) ? rd_q : ALU_Res;
        end else begin
            WB_ENout <= 1'b0;
        end
    end

endmodule
